// File: rtl/reg_bridge.sv
// reg_bridge: byte-stream packet bridge to a register port.
// Decodes write/read/burst-read commands and answers on the Tx stream.
package reg_bridge_pkg;
  typedef struct packed {
    logic        Valid;
    logic        SoP;
    logic [15:0] Length;
    logic [7:0]  Destination;
    logic [7:0]  Source;
    logic [7:0]  Data;
  } UART_PACKET;
endpackage

module reg_bridge
  import reg_bridge_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 8,
  parameter int MAX_BURST  = 16,
  parameter int WR_ACK     = 1
) (
  input  logic                    ipClk,
  input  logic                    ipReset,
  input  UART_PACKET              ipRxPkt,
  output UART_PACKET              opTxPkt,
  input  logic                    ipTxReady,
  output logic [ADDR_W-1:0]       opAddress,
  output logic [8*DATA_BYTES-1:0] opWrData,
  output logic                    opWrEnable,
  input  logic [8*DATA_BYTES-1:0] ipRdData
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int IW = 4;

  typedef enum logic [2:0] {
    IDLE, WR_DATA, RD_WAIT, RD_SEND, STATUS, DISCARD
  } state_t;

  state_t            state, stateN;
  UART_PACKET        txN;
  logic [ADDR_W-1:0] opAddressN;
  logic [DW-1:0]     opWrDataN;
  logic              opWrEnableN;
  logic [DW-1:0]     wordBuf, wordBufN, wordTmp;
  logic [DW-1:0]     rdWord, rdWordN;
  logic [IW-1:0]     byteIdx, byteIdxN;
  logic [15:0]       remain, remainN;
  logic [15:0]       rspLen, rspLenN;
  logic [7:0]        wordsLeft, wordsLeftN;
  logic [7:0]        burstCnt;
  logic [7:0]        status, statusN;
  logic [7:0]        rspDest, rspDestN;
  logic [7:0]        rspSrc, rspSrcN;
  logic              cntPend, cntPendN;
  logic              txFirst, txFirstN;
  logic              rxByte, rxSop;

  // next-state and datapath: state-specific work, then new-packet decode overrides
  always_comb begin
    stateN      = state;
    txN         = opTxPkt;
    opAddressN  = opWrEnable ? opAddress + 1'b1 : opAddress;
    opWrDataN   = opWrData;
    opWrEnableN = 1'b0;
    wordBufN    = wordBuf;
    wordTmp     = wordBuf;
    rdWordN     = rdWord;
    byteIdxN    = byteIdx;
    remainN     = remain;
    rspLenN     = rspLen;
    wordsLeftN  = wordsLeft;
    burstCnt    = 8'd1;
    statusN     = status;
    rspDestN    = rspDest;
    rspSrcN     = rspSrc;
    cntPendN    = cntPend;
    txFirstN    = txFirst;
    rxByte      = ipRxPkt.Valid && !ipRxPkt.SoP;
    rxSop       = ipRxPkt.Valid && ipRxPkt.SoP;

    unique case (state)
      IDLE: begin
        if (cntPend && rxByte) begin
          if (ipRxPkt.Data == 8'd0)
            burstCnt = 8'd1;
          else if (ipRxPkt.Data > 8'(MAX_BURST))
            burstCnt = 8'(MAX_BURST);
          else
            burstCnt = ipRxPkt.Data;
          wordsLeftN = burstCnt;
          rspLenN    = 16'(burstCnt) * 16'(DATA_BYTES);
          cntPendN   = 1'b0;
          stateN     = RD_WAIT;
        end
      end
      WR_DATA: begin
        if (rxByte) begin
          wordTmp[8*byteIdx +: 8] = ipRxPkt.Data;
          wordBufN = wordTmp;
          remainN  = remain - 16'd1;
          if (byteIdx == IW'(DATA_BYTES - 1)) begin
            opWrDataN   = wordTmp;
            opWrEnableN = 1'b1;
            byteIdxN    = '0;
          end else begin
            byteIdxN = byteIdx + 1'b1;
          end
          if (remain == 16'd1) begin
            statusN = (byteIdx == IW'(DATA_BYTES - 1))
                      ? 8'h00 : 8'h01;
            stateN  = (WR_ACK != 0) ? STATUS : IDLE;
          end
        end
      end
      DISCARD: begin
        if (rxByte) begin
          remainN = remain - 16'd1;
          if (remain == 16'd1)
            stateN = STATUS;
        end
      end
      RD_WAIT: stateN = RD_SEND;
      RD_SEND: begin
        if (!opTxPkt.Valid) begin
          txN.Valid       = 1'b1;
          txN.SoP         = txFirst;
          txN.Length      = rspLen;
          txN.Destination = rspDest;
          txN.Source      = rspSrc;
          txN.Data        = ipRdData[7:0];
          rdWordN         = ipRdData;
          byteIdxN        = IW'(1);
        end else if (ipTxReady) begin
          txFirstN = 1'b0;
          if (byteIdx == IW'(DATA_BYTES)) begin
            txN.Valid  = 1'b0;
            opAddressN = opAddress + 1'b1;
            wordsLeftN = wordsLeft - 8'd1;
            stateN = (wordsLeft == 8'd1) ? IDLE : RD_WAIT;
          end else begin
            txN.SoP  = 1'b0;
            txN.Data = rdWord[8*byteIdx +: 8];
            byteIdxN = byteIdx + 1'b1;
          end
        end
      end
      STATUS: begin
        if (!opTxPkt.Valid) begin
          txN.Valid       = 1'b1;
          txN.SoP         = 1'b1;
          txN.Length      = 16'd1;
          txN.Destination = rspDest;
          txN.Source      = rspSrc;
          txN.Data        = status;
        end else if (ipTxReady) begin
          txN.Valid = 1'b0;
          stateN    = IDLE;
        end
      end
      default: stateN = IDLE;
    endcase

    if (rxSop && (state == IDLE || state == WR_DATA ||
                  state == DISCARD)) begin
      cntPendN    = 1'b0;
      byteIdxN    = '0;
      wordBufN    = '0;
      opWrEnableN = 1'b0;
      rspDestN    = ipRxPkt.Source;
      rspSrcN     = ipRxPkt.Destination;
      txFirstN    = 1'b1;
      remainN     = ipRxPkt.Length - 16'd1;
      if (ipRxPkt.Length == 16'd0) begin
        stateN = IDLE;
      end else begin
        case (ipRxPkt.Destination)
          8'h00: begin
            opAddressN = ipRxPkt.Data[ADDR_W-1:0];
            wordsLeftN = 8'd1;
            rspLenN    = 16'(DATA_BYTES);
            stateN     = RD_WAIT;
          end
          8'h01: begin
            opAddressN = ipRxPkt.Data[ADDR_W-1:0];
            statusN    = 8'h00;
            if (ipRxPkt.Length == 16'd1)
              stateN = (WR_ACK != 0) ? STATUS : IDLE;
            else
              stateN = WR_DATA;
          end
          8'h02: begin
            opAddressN = ipRxPkt.Data[ADDR_W-1:0];
            if (ipRxPkt.Length >= 16'd2) begin
              cntPendN = 1'b1;
              stateN   = IDLE;
            end else begin
              wordsLeftN = 8'd1;
              rspLenN    = 16'(DATA_BYTES);
              stateN     = RD_WAIT;
            end
          end
          default: begin
            statusN = 8'h02;
            stateN  = (ipRxPkt.Length == 16'd1) ? STATUS : DISCARD;
          end
        endcase
      end
    end
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state      <= IDLE;
      opTxPkt    <= '0;
      opAddress  <= '0;
      opWrData   <= '0;
      opWrEnable <= 1'b0;
      wordBuf    <= '0;
      rdWord     <= '0;
      byteIdx    <= '0;
      remain     <= '0;
      rspLen     <= '0;
      wordsLeft  <= '0;
      status     <= '0;
      rspDest    <= '0;
      rspSrc     <= '0;
      cntPend    <= 1'b0;
      txFirst    <= 1'b0;
    end else begin
      state      <= stateN;
      opTxPkt    <= txN;
      opAddress  <= opAddressN;
      opWrData   <= opWrDataN;
      opWrEnable <= opWrEnableN;
      wordBuf    <= wordBufN;
      rdWord     <= rdWordN;
      byteIdx    <= byteIdxN;
      remain     <= remainN;
      rspLen     <= rspLenN;
      wordsLeft  <= wordsLeftN;
      status     <= statusN;
      rspDest    <= rspDestN;
      rspSrc     <= rspSrcN;
      cntPend    <= cntPendN;
      txFirst    <= txFirstN;
    end
  end

endmodule

// File: tb/tb_reg_bridge.sv
// tb_reg_bridge: directed and random packets against a packet-level model.
// Register file is simulated; expected values come from the bench's own map.
module tb_reg_bridge;
  import reg_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        memInit = 1'b1;
  UART_PACKET  rx, tx;
  logic [7:0]  addr;
  logic [31:0] wrData, rdData;
  logic        wrEn;

  int checks = 0;
  int failures = 0;
  int readyMode = 0;
  int gapMax = 0;

  logic [31:0] regs[256];
  logic [31:0] mdl[256];
  logic [39:0] sQ[$];
  UART_PACKET  txQ[$];

  always #5 clk = ~clk;

  reg_bridge #(
    .DATA_BYTES(4), .ADDR_W(8), .MAX_BURST(16), .WR_ACK(1)
  ) dut (
    .ipClk(clk), .ipReset(rst), .ipRxPkt(rx), .opTxPkt(tx),
    .ipTxReady(ready), .opAddress(addr), .opWrData(wrData),
    .opWrEnable(wrEn), .ipRdData(rdData)
  );

  function automatic logic [31:0] seed(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5AC3_0F00;
  endfunction

  // simulated register file: registered read, strobed write
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) regs[i] <= seed(i);
    end else begin
      rdData <= regs[addr];
      if (wrEn) regs[addr] <= wrData;
    end
  end

  // observe strobes and transferred Tx bytes mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (wrEn) sQ.push_back({addr, wrData});
      if (tx.Valid && ready) txQ.push_back(tx);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (readyMode)
      0: ready = 1'b1;
      1: ready = ~ready;
      2: ready = 1'($urandom_range(0, 1));
      default: ready = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic UART_PACKET pk(input logic sop,
    input logic [15:0] len, input logic [7:0] d,
    input logic [7:0] s, input logic [7:0] data);
    UART_PACKET p;
    p.Valid = 1'b1; p.SoP = sop; p.Length = len;
    p.Destination = d; p.Source = s; p.Data = data;
    return p;
  endfunction

  function automatic logic [40:0] fld(input UART_PACKET p);
    return {p.SoP, p.Length, p.Destination, p.Source, p.Data};
  endfunction

  task automatic sendByte(input logic sop, input logic [15:0] len,
    input logic [7:0] d, input logic [7:0] s, input logic [7:0] data);
    int g;
    rx = pk(sop, len, d, s, data);
    @(posedge clk); #1;
    rx = '0;
    g = $urandom_range(0, gapMax);
    repeat (g) begin @(posedge clk); #1; end
  endtask

  task automatic settle(input string tag, input logic [39:0] es[$],
                        input UART_PACKET et[$]);
    int cyc = 0;
    while (txQ.size() < et.size() && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    repeat (8) @(negedge clk);
    chk({tag, "_txcount"}, 64'(txQ.size()), 64'(et.size()));
    for (int i = 0; i < et.size() && i < txQ.size(); i++)
      chk($sformatf("%s_tx%0d", tag, i), 64'(fld(txQ[i])),
          64'(fld(et[i])));
    chk({tag, "_wrcount"}, 64'(sQ.size()), 64'(es.size()));
    for (int i = 0; i < es.size() && i < sQ.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 64'(sQ[i]), 64'(es[i]));
    sQ.delete();
    txQ.delete();
    @(posedge clk); #1;
  endtask

  // expected behaviour computed at packet level from the command rules
  task automatic doPkt(input string tag, input logic [7:0] d,
                       input logic [7:0] s, input logic [7:0] b[$]);
    logic [39:0] es[$];
    UART_PACKET  et[$];
    int n = b.size();
    int cnt, nw;
    logic [7:0]  a;
    logic [31:0] w;
    if (n == 0) begin
      sendByte(1'b1, 16'd0, d, s, 8'h00);
    end else begin
      if (d == 8'h00 || d == 8'h02) begin
        cnt = 1;
        if (d == 8'h02 && n > 1)
          cnt = (b[1] == 0) ? 1 : ((b[1] > 16) ? 16 : int'(b[1]));
        for (int k = 0; k < cnt; k++) begin
          a = b[0] + 8'(k);
          for (int j = 0; j < 4; j++)
            et.push_back(pk(k == 0 && j == 0, 16'(cnt * 4), s, d,
                            mdl[a][8*j +: 8]));
        end
      end else if (d == 8'h01) begin
        nw = (n - 1) / 4;
        for (int k = 0; k < nw; k++) begin
          a = b[0] + 8'(k);
          w = {b[4*k+4], b[4*k+3], b[4*k+2], b[4*k+1]};
          es.push_back({a, w});
          mdl[a] = w;
        end
        et.push_back(pk(1'b1, 16'd1, s, d,
                        ((n - 1) % 4 != 0) ? 8'h01 : 8'h00));
      end else begin
        et.push_back(pk(1'b1, 16'd1, s, d, 8'h02));
      end
      for (int i = 0; i < n; i++)
        sendByte(i == 0, 16'(n), d, s, b[i]);
    end
    settle(tag, es, et);
  endtask

  initial begin
    logic [7:0] b[$];
    logic [7:0] d, s;
    int kind, n, cyc;
    rx = '0;
    for (int i = 0; i < 256; i++) mdl[i] = seed(i);
    repeat (3) @(posedge clk);
    #1 memInit = 1'b0;
    @(negedge clk);
    chk("rst_txvalid", 64'(tx.Valid), 64'd0);
    chk("rst_txpkt", 64'(fld(tx)), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_wrdata", 64'(wrData), 64'd0);
    chk("rst_wren", 64'(wrEn), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    readyMode = 0;
    b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14,
          8'h15, 8'h16, 8'h17, 8'h18};
    doPkt("write9", 8'h01, 8'h09, b);
    b = '{8'h10, 8'h02};
    doPkt("readback", 8'h02, 8'h09, b);

    readyMode = 1;
    b = '{8'hFE, 8'h03};
    doPkt("burstwrap", 8'h02, 8'h05, b);

    readyMode = 0;
    b = '{8'h20, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
    doPkt("badlen", 8'h01, 8'h0C, b);

    b = '{8'h00, 8'h00, 8'h00};
    doPkt("unknown", 8'h7A, 8'h33, b);

    sendByte(1'b1, 16'd9, 8'h01, 8'h44, 8'h30);
    sendByte(1'b0, 16'd0, 8'h00, 8'h00, 8'hC1);
    sendByte(1'b0, 16'd0, 8'h00, 8'h00, 8'hC2);
    b = '{8'h40, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    doPkt("abort", 8'h01, 8'h44, b);

    b = {};
    doPkt("len0", 8'h00, 8'h11, b);
    b = '{8'h40};
    doPkt("single", 8'h00, 8'h21, b);

    readyMode = 2;
    b = '{8'h80, 8'h40};
    doPkt("clamp", 8'h02, 8'h22, b);
    b = '{8'h90, 8'h00};
    doPkt("cnt0", 8'h02, 8'h23, b);

    readyMode = 3;
    sendByte(1'b1, 16'd2, 8'h02, 8'h07, 8'h50);
    sendByte(1'b0, 16'd0, 8'h00, 8'h00, 8'h04);
    cyc = 0;
    while (!tx.Valid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("rst_pre_valid", 64'(tx.Valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_valid", 64'(tx.Valid), 64'd0);
    chk("rst_mid_pkt", 64'(fld(tx)), 64'd0);
    chk("rst_mid_wren", 64'(wrEn), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    sQ.delete();
    txQ.delete();
    readyMode = 1;
    b = '{8'h51};
    doPkt("after_rst", 8'h00, 8'h07, b);

    gapMax = 2;
    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 3);
      readyMode = $urandom_range(0, 2);
      s = 8'($urandom);
      b.delete();
      b.push_back(8'($urandom));
      case (kind)
        0: begin
          d = 8'h01;
          n = $urandom_range(1, 13);
          for (int i = 1; i < n; i++) b.push_back(8'($urandom));
        end
        1: begin
          d = 8'h02;
          b.push_back(8'($urandom_range(0, 20)));
        end
        2: d = 8'h00;
        default: begin
          d = 8'($urandom_range(3, 255));
          n = $urandom_range(1, 4);
          for (int i = 1; i < n; i++) b.push_back(8'($urandom));
        end
      endcase
      doPkt($sformatf("rnd%0d", it), d, s, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bridge.md
REG_BRIDGE -- requirements
Module: reg_bridge

Interface
REQ-001 Parameter DATA_BYTES, default 4, register word width in bytes (1..8).
REQ-002 Parameter ADDR_W, default 8, register address width in bits (1..8).
REQ-003 Parameter MAX_BURST, default 16, maximum words per read burst (1..255).
REQ-004 Parameter WR_ACK, default 1, 1 = send a status packet after every write packet; 0 = no write response.
REQ-005 ipClk  input  1  single clock; every register updates on its rising edge.
REQ-006 ipReset  input  1  reset; synchronous and active-high.
REQ-007 ipRxPkt  input  UART_PACKET  received byte stream: Valid, SoP, Length, Destination, Source, Data[7:0].
REQ-008 opTxPkt  output  UART_PACKET  transmitted byte stream, same fields.
REQ-009 ipTxReady  input  1  transmitter accepts the current opTxPkt byte this cycle.
REQ-010 opAddress  output  ADDR_W  register address.
REQ-011 opWrData  output  8*DATA_BYTES  register write data.
REQ-012 opWrEnable  output  1  one-cycle write strobe.
REQ-013 ipRdData  input  8*DATA_BYTES  register read data, valid one cycle after opAddress changes.

Function
REQ-014 Rx byte is consumed only when ipRxPkt.Valid=1; the SoP byte carries Length, Destination and Source; Data of the SoP byte is payload byte 0.
REQ-015 Command decode on Destination: 0x00 single read, 0x01 write burst, 0x02 read burst, any other value = unknown.
REQ-016 States: IDLE, WR_DATA, RD_WAIT, RD_SEND, STATUS, DISCARD.
REQ-017 Write (0x01): byte 0 = start address; remaining bytes form words, little-endian (first byte = LSB); state WR_DATA.
REQ-018 On each completed word, opWrData = word and opWrEnable = 1 for exactly one cycle, with opAddress stable that cycle; opAddress then increments by 1, modulo 2^ADDR_W.
REQ-019 Write completes after Length bytes; Length-1 not a multiple of DATA_BYTES -> trailing partial word dropped (no strobe) and status 0x01; otherwise status 0x00.
REQ-020 Write completion with WR_ACK=1 -> STATUS; with WR_ACK=0 -> IDLE.
REQ-021 Single read (0x00): byte 0 = address; word count 1.
REQ-022 Read burst (0x02): byte 0 = address, byte 1 = count; count 0 treated as 1; count > MAX_BURST clamped to MAX_BURST.
REQ-023 Read flow: set opAddress -> RD_WAIT for one cycle -> capture ipRdData -> RD_SEND.
REQ-024 RD_SEND emits DATA_BYTES bytes per word, LSB first; then increments opAddress (wrapping) and returns to RD_WAIT until count words are sent, then IDLE.
REQ-025 Response header: Length = words*DATA_BYTES; Destination = Rx Source; Source = Rx Destination; SoP=1 on the first byte only.
REQ-026 Tx handshake: a byte is transferred on a cycle with opTxPkt.Valid=1 and ipTxReady=1; Valid and Data hold until transferred; Valid=0 in IDLE.
REQ-027 Unknown destination -> DISCARD remaining Length-1 bytes, then STATUS with status 0x02.
REQ-028 STATUS sends one byte: Length=1, SoP=1, Data = status, addressing swapped per REQ-025; then IDLE.
REQ-029 SoP received while in WR_DATA or DISCARD aborts the current packet with no partial-word strobe, no status, and decodes the new packet.
REQ-030 Rx bytes arriving while in RD_WAIT, RD_SEND or STATUS are dropped; the sender must wait for the response.
REQ-031 Length=0 on SoP -> packet ignored; remain in IDLE.

Reset
REQ-032 ipReset=1 at a rising edge -> next cycle: state IDLE, opTxPkt all fields 0, opAddress 0, opWrData 0, opWrEnable 0, all counters 0.
REQ-033 Reset mid-operation abandons any packet in progress; no strobe and no Tx byte occur in the cycle after reset.

Verification
REQ-034 Write: Dest 0x01, Len 9, addr 0x10, bytes 11..18 -> strobe addr 0x10 data 0x14131211, strobe addr 0x11 data 0x18171615, then status 0x00.
REQ-035 Burst read: Dest 0x02, Src 0x05, addr 0xFE, count 3, ipTxReady toggling -> 12 bytes from 0xFE, 0xFF, 0x00 (wrap), Length 12, Dest 0x05, Source 0x02, SoP on byte 1 only.
REQ-036 Bad length: Dest 0x01, Len 7, addr 0x20 -> one strobe at 0x20, partial word dropped, status 0x01.
REQ-037 Unknown: Dest 0x7A, Len 3 -> no strobe, status packet Data 0x02.
REQ-038 Abort: new SoP after 2 write data bytes -> no strobe for the aborted packet; new packet handled normally.
REQ-039 Reset asserted during RD_SEND -> Valid=0 the next cycle; the next read command is answered correctly.
